wb_burst_master: RTL and testbench
==================================

WB_BURST_MASTER -- requirements
Module: wb_burst_master

Interface
REQ-001 SHALL have parameter BURST_BITS, default 2: burst length = 2**BURST_BITS 32-bit words.
REQ-002 SHALL have parameter TIMEOUT, default 255: cycles without ack/err before abort; 0 disables.
REQ-003 SHALL have the following ports, clock and reset first:
- clk  in  1  sole clock; Wishbone master side is synchronous to it.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  burst request.
- req_we  in  1  1 = write burst, 0 = read burst.
- req_addr  in  30-BURST_BITS  burst-aligned word address, bits [31:2+BURST_BITS].
- req_sel  in  4  byte select, applied to every beat.
- req_ready  out  1  request accepted when req_valid && req_ready.
- wr_data  in  32  write word.
- wr_valid  in  1  wr_data valid.
- wr_ready  out  1  write word consumed.
- rd_data  out  32  read word.
- rd_valid  out  1  rd_data valid, one cycle per beat.
- done  out  1  one-cycle pulse at burst end.
- err  out  1  one-cycle pulse with done on bus error or timeout.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone cycle, strobe, write enable.
- wbm_addr_o  out  30  word address [31:2].
- wbm_cti_o  out  3  cycle type.
- wbm_bte_o  out  2  burst type.
- wbm_sel_o  out  4  byte select.
- wbm_data_o  out  32  write data.
- wbm_data_i  in  32  read data.
- wbm_ack_i, wbm_err_i  in  1 each  slave acknowledge, slave error.

Function
REQ-004 SHALL implement states IDLE, LOAD, BUS, DONE.
REQ-005 SHALL drive req_ready=1 only in IDLE.
REQ-006 On acceptance, SHALL latch req_we, req_addr, req_sel; write -> LOAD, read -> BUS.
REQ-007 LOAD: SHALL assert wr_ready and store one wr_data per cycle with wr_valid into the 2**BURST_BITS-entry buffer; SHALL go to BUS the cycle after the last word is stored.
REQ-008 SHALL assert wr_ready only in LOAD.
REQ-009 BUS: SHALL hold wbm_cyc_o=wbm_stb_o=1.
REQ-010 BUS: SHALL hold wbm_we_o = latched we and wbm_sel_o = latched sel.
REQ-011 BUS: SHALL hold wbm_bte_o=2'b00.
REQ-012 BUS: SHALL set wbm_addr_o = {base, beat}, beat = 0 on entry.
REQ-013 BUS: wbm_cti_o SHALL be 3'b010 on non-final beats and 3'b111 on the final beat; with BURST_BITS=0, the only beat is 3'b111.
REQ-014 SHALL sample ack and err on the clock edge. On ack, beat SHALL advance next cycle, and address and write data SHALL update with it.
REQ-015 Write: wbm_data_o SHALL equal buffer[beat]; it SHALL be 0 outside BUS.
REQ-016 Read: on each ack, rd_data SHALL register wbm_data_i and rd_valid SHALL pulse the next cycle.
REQ-017 On ack of the final beat -> DONE: next cycle cyc=stb=0 and done=1 for one cycle; then IDLE.
REQ-018 wbm_err_i SHALL win over a simultaneous ack: no rd_valid for that beat; -> DONE with err=1.
REQ-019 BUS with TIMEOUT>0: the counter SHALL reset on each ack and increment otherwise; at TIMEOUT -> DONE with err=1.
REQ-020 An ack or err outside BUS SHALL be ignored.
REQ-021 No new request SHALL be accepted in the DONE cycle; minimum gap between bursts is 1 idle cycle (IDLE).
REQ-022 All outputs SHALL be registered except req_ready and wr_ready, which decode state.

Reset
REQ-023 On rst=1 at a clock edge, state SHALL become IDLE and the following SHALL be 0: wbm_cyc_o, stb, we, addr, cti, bte, sel, data_o, rd_data, rd_valid, done, err, beat, timeout counter.
REQ-024 rst mid-burst SHALL drop cyc/stb the next cycle and discard buffered data, with no done pulse.
REQ-025 After reset release, req_ready SHALL be 1 in the first cycle.

Verification
REQ-026 Read burst, BURST_BITS=2, req_addr=0x100, slave acks every cycle -> wbm_addr_o 0x400..0x403 with cti 010,010,010,111; 4 rd_valid pulses; done 1 cycle after the last ack.
REQ-027 Write burst with words 0x11111111..0x44444444 and sel=4'b0011 -> LOAD lasts 4 cycles; bus shows the 4 words in order with sel=0011 and we=1.
REQ-028 Slave inserts 3 wait cycles before ack on beat 1 -> addr and data hold steady during the wait; order is unchanged.
REQ-029 wbm_err_i together with ack on beat 2 of a read -> 2 rd_valid pulses only; done=err=1; cyc=0 next cycle.
REQ-030 TIMEOUT=8, slave never acks -> err at cycle 8 of BUS; req_ready=1 two cycles later.
REQ-031 rst asserted during beat 1 of a write -> next cycle all outputs 0, done=0, req_ready=1.

Source files
------------

// File: rtl/wb_burst_master.sv
// Purpose: Wishbone B4 incrementing-burst master; the write data is buffered locally before the bus phase.
// Latency: a read burst starts on the bus the cycle after acceptance. A write burst starts the cycle after its last word is loaded.
// Backpressure: req_ready is high only in IDLE. wr_ready is high only in LOAD. The slave stalls beats by withholding ack.
//
// Ports:
//   clk, rst                      sole clock, synchronous active-high reset
//   req_valid/req_ready           burst request handshake (req_we, req_addr, req_sel)
//   wr_data/wr_valid/wr_ready     write-word stream, consumed during LOAD
//   rd_data/rd_valid              one registered read word per acked beat
//   done/err                      one-cycle completion pulse; err marks a bus error or timeout
//   wbm_*                         Wishbone master bus (cyc, stb, we, addr, cti, bte, sel, data, ack, err)
module wb_burst_master #(
  parameter int BURST_BITS = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_we,
  input  logic [29-BURST_BITS:0]  req_addr,
  input  logic [3:0]              req_sel,
  output logic                    req_ready,
  input  logic [31:0]             wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [31:0]             rd_data,
  output logic                    rd_valid,
  output logic                    done,
  output logic                    err,
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_we_o,
  output logic [29:0]             wbm_addr_o,
  output logic [2:0]              wbm_cti_o,
  output logic [1:0]              wbm_bte_o,
  output logic [3:0]              wbm_sel_o,
  output logic [31:0]             wbm_data_o,
  input  logic [31:0]             wbm_data_i,
  input  logic                    wbm_ack_i,
  input  logic                    wbm_err_i
);

  localparam int BEATS = 1 << BURST_BITS;
  localparam int BW    = (BURST_BITS > 0) ? BURST_BITS : 1;
  localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, BUS, DONE} state_t;

  state_t        state_q, state_d;
  logic          lat_we_q, lat_we_d;
  logic [3:0]    lat_sel_q, lat_sel_d;
  logic [29:0]   base_q, base_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   buf_q [BEATS];
  logic [31:0]   buf_d [BEATS];
  logic          cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [29:0]   addr_q, addr_d;
  logic [2:0]    cti_q, cti_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   data_o_q, data_o_d, rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d, done_q, done_d, err_q, err_d;
  logic          timeout_hit;

  assign timeout_hit = (TIMEOUT > 0) && (tmo_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    lat_we_d   = lat_we_q;
    lat_sel_d  = lat_sel_q;
    base_d     = base_q;
    beat_d     = beat_q;
    tmo_d      = tmo_q;
    buf_d      = buf_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cyc_d      = 1'b0;
    stb_d      = 1'b0;
    we_d       = 1'b0;
    addr_d     = '0;
    cti_d      = 3'b000;
    sel_d      = 4'h0;
    data_o_d   = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          lat_we_d  = req_we;
          lat_sel_d = req_sel;
          base_d    = 30'(req_addr) << BURST_BITS;
          beat_d    = '0;
          tmo_d     = '0;
          state_d   = req_we ? LOAD : BUS;
        end
      end
      LOAD: begin
        // beat_q doubles as the fill index while loading.
        if (wr_valid) begin
          buf_d[beat_q] = wr_data;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = BUS;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      BUS: begin
        if (wbm_err_i) begin
          // An error overrides a simultaneous ack, so that beat produces no read data.
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (wbm_ack_i) begin
          tmo_d = '0;
          if (!lat_we_q) begin
            rd_data_d  = wbm_data_i;
            rd_valid_d = 1'b1;
          end
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end else if (timeout_hit) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (TIMEOUT > 0) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The bus outputs are registered from the next-cycle beat, so address, cti and data change with the beat.
    if (state_d == BUS) begin
      cyc_d    = 1'b1;
      stb_d    = 1'b1;
      we_d     = lat_we_d;
      sel_d    = lat_sel_d;
      addr_d   = base_d | 30'(beat_d);
      cti_d    = (beat_d == LAST_BEAT) ? 3'b111 : 3'b010;
      data_o_d = lat_we_d ? buf_d[beat_d] : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lat_we_q   <= 1'b0;
      lat_sel_q  <= 4'h0;
      base_q     <= '0;
      beat_q     <= '0;
      tmo_q      <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      cti_q      <= 3'b000;
      sel_q      <= 4'h0;
      data_o_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_we_q   <= lat_we_d;
      lat_sel_q  <= lat_sel_d;
      base_q     <= base_d;
      beat_q     <= beat_d;
      tmo_q      <= tmo_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      cti_q      <= cti_d;
      sel_q      <= sel_d;
      data_o_q   <= data_o_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // The buffer needs no reset: every burst refills it completely before any of it is driven.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign req_ready  = (state_q == IDLE);
  assign wr_ready   = (state_q == LOAD);
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign done       = done_q;
  assign err        = err_q;
  assign wbm_cyc_o  = cyc_q;
  assign wbm_stb_o  = stb_q;
  assign wbm_we_o   = we_q;
  assign wbm_addr_o = addr_q;
  assign wbm_cti_o  = cti_q;
  assign wbm_bte_o  = 2'b00;
  assign wbm_sel_o  = sel_q;
  assign wbm_data_o = data_o_q;

endmodule

// File: tb/tb_wb_burst_master.sv
module tb_wb_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [27:0] req_addr;
  logic [3:0]  req_sel;
  logic        req_ready;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, done, err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [29:0] wbm_addr_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_data_o, wbm_data_i;
  logic        wbm_ack_i, wbm_err_i;

  int tests = 0;
  int fails = 0;

  wb_burst_master #(.BURST_BITS(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_sel(req_sel),
    .req_ready(req_ready),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_addr_o(wbm_addr_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_sel_o(wbm_sel_o), .wbm_data_o(wbm_data_o), .wbm_data_i(wbm_data_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge; inputs changed here reach the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_sel = '0;
    wr_data = '0; wr_valid = 1'b0; wbm_data_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    step(); step();

    // Reset state
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_stb", wbm_stb_o, 0);
    chk("rst_addr", wbm_addr_o, 0);
    chk("rst_cti", wbm_cti_o, 0);
    chk("rst_data_o", wbm_data_o, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    chk("rst_req_ready", req_ready, 1);

    // Read burst at 0x100, slave acks every cycle
    req_valid = 1'b1; req_we = 1'b0; req_addr = 28'h100; req_sel = 4'hF;
    step();
    req_valid = 1'b0;
    wbm_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wbm_data_i = 32'hA000_0000 + i;
      chk("rd_cyc", wbm_cyc_o, 1);
      chk("rd_stb", wbm_stb_o, 1);
      chk("rd_we", wbm_we_o, 0);
      chk("rd_addr", wbm_addr_o, 30'h400 + i);
      chk("rd_cti", wbm_cti_o, (i == 3) ? 3'b111 : 3'b010);
      chk("rd_bte", wbm_bte_o, 0);
      chk("rd_sel", wbm_sel_o, 4'hF);
      chk("rd_req_ready_busy", req_ready, 0);
      step();
      chk("rd_valid", rd_valid, 1);
      chk("rd_data", rd_data, 32'hA000_0000 + i);
    end
    wbm_ack_i = 1'b0;
    chk("rd_done", done, 1);
    chk("rd_err", err, 0);
    chk("rd_cyc_end", wbm_cyc_o, 0);
    chk("rd_no_accept_in_done", req_ready, 0);
    step();
    chk("rd_done_pulse", done, 0);
    chk("rd_valid_end", rd_valid, 0);
    chk("rd_idle_ready", req_ready, 1);

    // Ack and err in IDLE are ignored
    wbm_ack_i = 1'b1; wbm_err_i = 1'b1;
    step();
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    chk("idle_ack_done", done, 0);
    chk("idle_ack_err", err, 0);
    chk("idle_ack_rdv", rd_valid, 0);

    // Write burst, sel 0011, three wait states on beat 1
    req_valid = 1'b1; req_we = 1'b1; req_addr = 28'h040; req_sel = 4'b0011;
    step();
    req_valid = 1'b0;
    chk("wr_load_cyc", wbm_cyc_o, 0);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data = 32'h1111_1111 * (i + 1);
      chk("wr_ready_load", wr_ready, 1);
      step();
    end
    wr_valid = 1'b0;
    chk("wr_ready_bus", wr_ready, 0);
    for (int b = 0; b < 4; b++) begin
      for (int w = 0; w < ((b == 1) ? 3 : 0); w++) begin
        wbm_ack_i = 1'b0;
        chk("wr_wait_addr", wbm_addr_o, 30'h100 + b);
        chk("wr_wait_data", wbm_data_o, 32'h1111_1111 * (b + 1));
        step();
      end
      wbm_ack_i = 1'b1;
      chk("wr_addr", wbm_addr_o, 30'h100 + b);
      chk("wr_data_o", wbm_data_o, 32'h1111_1111 * (b + 1));
      chk("wr_we", wbm_we_o, 1);
      chk("wr_sel", wbm_sel_o, 4'b0011);
      chk("wr_cti", wbm_cti_o, (b == 3) ? 3'b111 : 3'b010);
      step();
    end
    wbm_ack_i = 1'b0;
    chk("wr_done", done, 1);
    chk("wr_no_rdv", rd_valid, 0);
    chk("wr_data_o_idle", wbm_data_o, 0);
    step();

    // Read with err+ack on beat 2
    req_valid = 1'b1; req_we = 1'b0; req_addr = 28'h010; req_sel = 4'hF;
    step();
    req_valid = 1'b0;
    wbm_ack_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wbm_data_i = 32'hB000_0000 + i;
      step();
      chk("er_rdv", rd_valid, 1);
    end
    wbm_err_i = 1'b1; wbm_data_i = 32'hDEAD_BEEF;
    chk("er_addr_beat2", wbm_addr_o, 30'h042);
    step();
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
    chk("er_no_rdv", rd_valid, 0);
    chk("er_rd_data_hold", rd_data, 32'hB000_0001);
    chk("er_done", done, 1);
    chk("er_err", err, 1);
    chk("er_cyc", wbm_cyc_o, 0);
    step();
    chk("er_err_pulse", err, 0);

    // Timeout: the slave never responds
    req_valid = 1'b1; req_we = 1'b0; req_addr = 28'h020;
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk("to_cyc", wbm_cyc_o, 1);
      chk("to_no_err", err, 0);
      step();
    end
    chk("to_err", err, 1);
    chk("to_done", done, 1);
    chk("to_cyc_end", wbm_cyc_o, 0);
    chk("to_not_ready", req_ready, 0);
    step();
    chk("to_ready", req_ready, 1);

    // Reset during beat 1 of a write
    req_valid = 1'b1; req_we = 1'b1; req_addr = 28'h030; req_sel = 4'hC;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data = 32'hC000_0000 + i;
      step();
    end
    wr_valid = 1'b0;
    wbm_ack_i = 1'b1;
    step();
    wbm_ack_i = 1'b0;
    chk("mr_addr_beat1", wbm_addr_o, 30'h0C1);
    rst = 1'b1;
    step();
    chk("mr_cyc", wbm_cyc_o, 0);
    chk("mr_stb", wbm_stb_o, 0);
    chk("mr_we", wbm_we_o, 0);
    chk("mr_addr", wbm_addr_o, 0);
    chk("mr_sel", wbm_sel_o, 0);
    chk("mr_data_o", wbm_data_o, 0);
    chk("mr_rd_data", rd_data, 0);
    chk("mr_done", done, 0);
    chk("mr_err", err, 0);
    chk("mr_req_ready", req_ready, 1);
    rst = 1'b0;
    step();
    chk("mr_idle_cyc", wbm_cyc_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
